data_path: RTL and testbench
============================

# data_path

Single-bus 32-bit datapath for the teaching CPU: register file, special registers (PC, IR, MAR, MDR, HI, LO, Y, 64-bit Z), a one-hot-encoded bus multiplexer and an ALU. All control signals come from outside: the testbench today, the control unit later. The block only stores, routes and computes. Each cycle exactly one source drives the shared 32-bit bus, and any set of enabled destinations captures it on the rising clock edge.

## Interface
Parameters: none.

- clock  in  1  single system clock; all state updates on rising edge
- clear  in  1  reset; asynchronous and active-low; clears all state to 0
- R0in..R15in  in  1 each  load enable for general register Rn
- HIin, LOin  in  1 each  load enables for HI and LO
- MARin, PCin, IRin  in  1 each  load enables for MAR, PC, IR
- MDRin  in  1  load enable for MDR
- RYin  in  1  load enable for Y
- RZin  in  1  load enable for Z (64-bit)
- Bus_Encoder_signals  in  24  one-hot bus source select; bit map below
- Mem_read  in  1  MDR input select: 1 = MDR_Mem_lines, 0 = bus
- opcode  in  5  ALU operation select
- MDR_Mem_lines  in  32  data from memory
- InPort_data  in  32  external input port value
- BusMuxOut  out  32  current bus value
- MAR_q  out  32  MAR contents
- IR_q  out  32  IR contents

## Operation
- Bus source bit map:
  - [15:0] = R0out..R15out
  - [16] = HIout, [17] = LOout
  - [18] = Zhighout, [19] = Zlowout
  - [20] = PCout, [21] = MDRout
  - [22] = InPortout, [23] = Cout
- Bus encoding: the 24 one-hot bits encode to a 5-bit select that drives a combinational mux.
  - No bit set: bus = 0.
  - Multiple bits set: the lowest set index wins.
- Cout drives C = IR[18:0] sign-extended to 32 bits.
- R0 is an ordinary storage register; it is not hard-wired to zero.
- MDR loads {Mem_read ? MDR_Mem_lines : bus} when MDRin = 1.
- ALU operands: A = Y, B = bus. Result is 64-bit {Zhi, Zlo}; Zhi = 0 except for MUL and DIV.
- ALU opcodes:
  - 00000 INC: Zlo = B + 1 (PC increment)
  - 00001 AND: A & B
  - 00010 OR: A | B
  - 00011 ADD: A + B
  - 00100 SUB: A − B
  - 00101 SHR: logical right shift
  - 00110 SHRA: arithmetic right shift
  - 00111 SHL: left shift
  - 01000 ROR: rotate right
  - 01001 ROL: rotate left
  - 01010 MUL: signed A×B, 64-bit result in {Zhi, Zlo}
  - 01011 DIV: signed; Zlo = quotient, Zhi = remainder
  - 01100 NEG: Zlo = −B
  - 01101 NOT: Zlo = ~B
  - others: Z = 0
- Shift and rotate: value = A, amount = B[4:0].
- ADD/SUB/INC wrap modulo 2^32, with no carry or flag output.
- DIV truncates toward zero; the remainder takes the sign of the dividend. B = 0 gives Z = 0.

## Timing
- Every register is an edge-triggered flip-flop with its own enable and captures on the rising edge.
- Bus and ALU are purely combinational; there is no added latency. Z captures the ALU result of the same cycle.
- A register can be read (out) and written (in) in the same cycle; the old value drives the bus and the new value appears after the edge.
- Multiple in-enables in one cycle: all enabled destinations load the same bus value.
- Reset: clear = 0 immediately forces all registers (R0–R15, HI, LO, PC, IR, MAR, MDR, Y, Z) and outputs MAR_q and IR_q to 0. This applies mid-operation and is independent of clock.
  - BusMuxOut reflects the zeroed sources.
  - On release, state holds 0 until the next enabled edge.
- An instruction sequence uses one cycle per T-state: fetch T0–T2, execute T3+.

## Test plan
- Register load:
  - MDR_Mem_lines = 0x12, Mem_read = MDRin = 1 for one edge → MDR = 0x12.
  - Then MDRout + R2in → R2 = 0x12.
  - Repeat with 0x14 → R3 and 0x18 → R1.
- Fetch:
  - PC = 0; T0: PCout, MARin, RZin, opcode 00000 → MAR = 0, Zlo = 1.
  - T1: Zlowout, PCin, Mem_read, MDRin with memory 0x28918000 → PC = 1, MDR = 0x28918000.
  - T2: MDRout, IRin → IR_q = 0x28918000.
- AND execute:
  - T3: R2out, RYin → Y = 0x12.
  - T4: R3out, opcode 00001, RZin → Zlo = 0x10.
  - T5: Zlowout, R1in → R1 = 0x10 (replacing 0x18).
- MUL/DIV:
  - Y = 0xFFFFFFFA (−6), bus = 4, MUL → Zhi = 0xFFFFFFFF, Zlo = 0xFFFFFFE8.
  - Y = −7, bus = 2, DIV → Zlo = 0xFFFFFFFD (−3), Zhi = 0xFFFFFFFF (−1).
  - DIV with bus = 0 → Z = 0.
- Shifts and rotates, Y = 0x80000001, bus = 1:
  - SHRA → 0xC0000000
  - SHR → 0x40000000
  - ROL → 0x00000003
  - ROR → 0xC0000000
- Bus priority and reset:
  - R2out and R5out both set → bus = R2.
  - No out bit set → bus = 0.
  - Assert clear = 0 between edges → all registers read 0 immediately.

Source files
------------

// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, special registers, priority bus mux and ALU.
// All control comes from outside; the block only stores, routes and computes.
module data_path (
   input  logic        clock,
   input  logic        clear,
   input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
   input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
   input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
   input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        MARin,
   input  logic        PCin,
   input  logic        IRin,
   input  logic        MDRin,
   input  logic        RYin,
   input  logic        RZin,
   input  logic [23:0] Bus_Encoder_signals,
   input  logic        Mem_read,
   input  logic [4:0]  opcode,
   input  logic [31:0] MDR_Mem_lines,
   input  logic [31:0] InPort_data,
   output logic [31:0] BusMuxOut,
   output logic [31:0] MAR_q,
   output logic [31:0] IR_q
);
   logic [31:0] r_rf [16];
   logic [31:0] r_hi, r_lo, r_pc, r_ir, r_mar, r_mdr, r_y;
   logic [63:0] r_z;

   logic [15:0] w_rin;
   logic [4:0]  w_sel;
   logic [31:0] w_bus;
   logic [31:0] w_c;
   logic [63:0] w_z;
   logic [63:0] w_prod;
   logic [4:0]  w_amt;
   logic [5:0]  w_inv;
   logic signed [31:0] w_sa, w_sb;

   assign w_rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

   // Scan high to low so the lowest set bit is the last one written; 31 means "no source".
   always_comb begin
      w_sel = 5'd31;
      for (int i = 23; i >= 0; i--)
         if (Bus_Encoder_signals[i]) w_sel = 5'(i);
   end

   assign w_c = {{13{r_ir[18]}}, r_ir[18:0]};

   always_comb begin
      w_bus = '0;
      if (w_sel < 5'd16) w_bus = r_rf[w_sel[3:0]];
      else begin
         case (w_sel)
            5'd16:   w_bus = r_hi;
            5'd17:   w_bus = r_lo;
            5'd18:   w_bus = r_z[63:32];
            5'd19:   w_bus = r_z[31:0];
            5'd20:   w_bus = r_pc;
            5'd21:   w_bus = r_mdr;
            5'd22:   w_bus = InPort_data;
            5'd23:   w_bus = w_c;
            default: w_bus = '0;
         endcase
      end
   end

   assign w_sa   = r_y;
   assign w_sb   = w_bus;
   assign w_amt  = w_bus[4:0];
   assign w_inv  = 6'd32 - {1'b0, w_amt};
   assign w_prod = {{32{r_y[31]}}, r_y} * {{32{w_bus[31]}}, w_bus};

   always_comb begin
      w_z = '0;
      case (opcode)
         5'b00000: w_z[31:0] = w_bus + 32'd1;
         5'b00001: w_z[31:0] = r_y & w_bus;
         5'b00010: w_z[31:0] = r_y | w_bus;
         5'b00011: w_z[31:0] = r_y + w_bus;
         5'b00100: w_z[31:0] = r_y - w_bus;
         5'b00101: w_z[31:0] = r_y >> w_amt;
         5'b00110: w_z[31:0] = w_sa >>> w_amt;
         5'b00111: w_z[31:0] = r_y << w_amt;
         // A shift by 32 yields 0, so a zero rotate amount falls out naturally.
         5'b01000: w_z[31:0] = (r_y >> w_amt) | (r_y << w_inv);
         5'b01001: w_z[31:0] = (r_y << w_amt) | (r_y >> w_inv);
         5'b01010: w_z = w_prod;
         5'b01011: if (w_bus != 32'd0) w_z = {w_sa % w_sb, w_sa / w_sb};
         5'b01100: w_z[31:0] = 32'd0 - w_bus;
         5'b01101: w_z[31:0] = ~w_bus;
         default:  w_z = '0;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_rf  <= '{default: '0};
         r_hi  <= '0;
         r_lo  <= '0;
         r_pc  <= '0;
         r_ir  <= '0;
         r_mar <= '0;
         r_mdr <= '0;
         r_y   <= '0;
         r_z   <= '0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (w_rin[i]) r_rf[i] <= w_bus;
         if (HIin)  r_hi  <= w_bus;
         if (LOin)  r_lo  <= w_bus;
         if (PCin)  r_pc  <= w_bus;
         if (IRin)  r_ir  <= w_bus;
         if (MARin) r_mar <= w_bus;
         if (MDRin) r_mdr <= Mem_read ? MDR_Mem_lines : w_bus;
         if (RYin)  r_y   <= w_bus;
         if (RZin)  r_z   <= w_z;
      end
   end

   assign BusMuxOut = w_bus;
   assign MAR_q     = r_mar;
   assign IR_q      = r_ir;
endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: expectations queued with stimulus, checked by routing
// the target register onto the bus (or reading MAR_q / IR_q).
module tb_data_path;
   localparam int ZH = 18, ZL = 19, PCO = 20, MDRO = 21, INP = 22, CO = 23;
   localparam int SRC_MAR = -1, SRC_IR = -2;

   logic        clock = 1'b0;
   logic        clear;
   logic [15:0] rin;
   logic        hiin, loin, marin, pcin, irin, mdrin, ryin, rzin;
   logic [23:0] enc;
   logic        mem_read;
   logic [4:0]  opcode;
   logic [31:0] mem, inport;
   logic [31:0] BusMuxOut, MAR_q, IR_q;

   typedef struct {
      string       tag;
      logic [31:0] exp;
      int          src;
   } exp_t;
   exp_t sb[$];

   int n_chk = 0;
   int n_err = 0;

   data_path dut (
      .clock(clock), .clear(clear),
      .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
      .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
      .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
      .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
      .HIin(hiin), .LOin(loin), .MARin(marin), .PCin(pcin), .IRin(irin),
      .MDRin(mdrin), .RYin(ryin), .RZin(rzin),
      .Bus_Encoder_signals(enc), .Mem_read(mem_read), .opcode(opcode),
      .MDR_Mem_lines(mem), .InPort_data(inport),
      .BusMuxOut(BusMuxOut), .MAR_q(MAR_q), .IR_q(IR_q)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rin = '0; hiin = 0; loin = 0; marin = 0; pcin = 0; irin = 0;
      mdrin = 0; ryin = 0; rzin = 0; enc = '0; mem_read = 0; opcode = '0;
   endtask

   task automatic cyc();
      @(posedge clock); #1;
      idle();
   endtask

   task automatic push(input string tag, input logic [31:0] exp, input int src);
      exp_t e;
      e.tag = tag; e.exp = exp; e.src = src;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.src == SRC_MAR) chk(e.tag, MAR_q, e.exp);
         else if (e.src == SRC_IR) chk(e.tag, IR_q, e.exp);
         else begin
            enc = '0; enc[e.src] = 1'b1; #1;
            chk(e.tag, BusMuxOut, e.exp);
            enc = '0;
         end
      end
   endtask

   task automatic rd(input int src, input string tag, input logic [31:0] exp);
      push(tag, exp, src);
      drain();
   endtask

   task automatic set_y(input logic [31:0] v);
      inport = v; enc[INP] = 1; ryin = 1; cyc();
   endtask

   task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] b,
                      input logic [63:0] exp);
      inport = b; enc[INP] = 1; opcode = op; rzin = 1;
      push({tag, "_lo"}, exp[31:0], ZL);
      push({tag, "_hi"}, exp[63:32], ZH);
      cyc();
      drain();
   endtask

   function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      int unsigned sh;
      logic [31:0] lo;
      longint p;
      sh = int'(b[4:0]);
      lo = '0;
      case (op)
         5'd0:  lo = b + 1;
         5'd1:  lo = a & b;
         5'd2:  lo = a | b;
         5'd3:  lo = a + b;
         5'd4:  lo = a - b;
         5'd5:  lo = a >> sh;
         5'd6:  begin
                   lo = a >> sh;
                   if (a[31] && sh != 0) lo = lo | ~(32'hFFFF_FFFF >> sh);
                end
         5'd7:  lo = a << sh;
         5'd8:  lo = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
         5'd9:  lo = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
         5'd10: begin
                   p = longint'(int'(a)) * longint'(int'(b));
                   return 64'(p);
                end
         5'd11: begin
                   if (b == 0) return 64'd0;
                   return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
                end
         5'd12: lo = -b;
         5'd13: lo = ~b;
         default: lo = '0;
      endcase
      return {32'd0, lo};
   endfunction

   initial begin
      logic [31:0] a, b;
      logic [4:0]  op;
      idle(); mem = '0; inport = '0;
      clear = 1'b1;
      #1 clear = 1'b0;
      #1;
      push("rst_mar", 32'd0, SRC_MAR);
      push("rst_ir", 32'd0, SRC_IR);
      push("rst_pc", 32'd0, PCO);
      push("rst_r0", 32'd0, 0);
      push("rst_zlo", 32'd0, ZL);
      drain();
      @(negedge clock); clear = 1'b1;

      // Register load through MDR
      mem = 32'h12; mem_read = 1; mdrin = 1; cyc();
      rd(MDRO, "mdr_load", 32'h12);
      enc[MDRO] = 1; rin[2] = 1; cyc();
      mem = 32'h14; mem_read = 1; mdrin = 1; cyc();
      enc[MDRO] = 1; rin[3] = 1; cyc();
      mem = 32'h18; mem_read = 1; mdrin = 1; cyc();
      enc[MDRO] = 1; rin[1] = 1; cyc();
      rd(2, "r2", 32'h12);
      rd(3, "r3", 32'h14);
      rd(1, "r1", 32'h18);

      // Fetch T0..T2
      enc[PCO] = 1; marin = 1; rzin = 1; opcode = 5'b00000;
      push("t0_mar", 32'd0, SRC_MAR);
      push("t0_zlo", 32'd1, ZL);
      cyc(); drain();
      enc[ZL] = 1; pcin = 1; mem_read = 1; mdrin = 1; mem = 32'h2891_8000;
      push("t1_pc", 32'd1, PCO);
      push("t1_mdr", 32'h2891_8000, MDRO);
      cyc(); drain();
      enc[MDRO] = 1; irin = 1;
      push("t2_ir", 32'h2891_8000, SRC_IR);
      cyc(); drain();
      rd(CO, "c_pos", 32'h0001_8000);

      // AND execute T3..T5
      enc[2] = 1; ryin = 1; cyc();
      enc[3] = 1; opcode = 5'b00001; rzin = 1;
      push("t4_and", 32'h10, ZL);
      cyc(); drain();
      enc[ZL] = 1; rin[1] = 1;
      push("t5_r1", 32'h10, 1);
      cyc(); drain();

      // Sign extension of C with IR[18] set
      inport = 32'h0007_FFFF; enc[INP] = 1; irin = 1; cyc();
      rd(CO, "c_neg", 32'hFFFF_FFFF);

      // MUL / DIV directed
      set_y(32'hFFFF_FFFA);
      alu("mul", 5'b01010, 32'd4, 64'hFFFF_FFFF_FFFF_FFE8);
      set_y(32'hFFFF_FFF9);
      alu("div", 5'b01011, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      alu("div0", 5'b01011, 32'd0, 64'd0);

      // Read Z and write Z in the same cycle: old value on bus, new after edge
      enc[ZL] = 1; opcode = 5'b00000; rzin = 1; #1;
      chk("rw_old_bus", BusMuxOut, 32'd0);
      push("rw_new_z", 32'd1, ZL);
      cyc(); drain();

      // Shifts and rotates
      set_y(32'h8000_0001);
      alu("shra", 5'b00110, 32'd1, 64'h0000_0000_C000_0000);
      alu("shr",  5'b00101, 32'd1, 64'h0000_0000_4000_0000);
      alu("rol",  5'b01001, 32'd1, 64'h0000_0000_0000_0003);
      alu("ror",  5'b01000, 32'd1, 64'h0000_0000_C000_0000);
      alu("ror0", 5'b01000, 32'd0, 64'h0000_0000_8000_0001);
      alu("bad_op", 5'b11111, 32'd1, 64'd0);

      // One bus value into several destinations
      inport = 32'h0000_A5A5; enc[INP] = 1; rin[6] = 1; rin[7] = 1; hiin = 1;
      push("multi_r6", 32'h0000_A5A5, 6);
      push("multi_r7", 32'h0000_A5A5, 7);
      push("multi_hi", 32'h0000_A5A5, 16);
      cyc(); drain();
      inport = 32'h0000_5A5A; enc[INP] = 1; loin = 1;
      push("lo", 32'h0000_5A5A, 17);
      cyc(); drain();

      // Random ALU operations against the model
      for (int i = 0; i < 24; i++) begin
         a  = $urandom();
         b  = $urandom();
         op = 5'($urandom_range(0, 15));
         if (op == 5'd11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         set_y(a);
         alu($sformatf("rnd%0d_op%0d", i, op), op, b, model(op, a, b));
      end

      // Bus priority
      inport = 32'h55; enc[INP] = 1; rin[5] = 1; cyc();
      enc[2] = 1; enc[5] = 1; #1;
      chk("prio_r2_r5", BusMuxOut, 32'h12);
      enc = '0; enc[INP] = 1; enc[CO] = 1; inport = 32'h77; #1;
      chk("prio_inp_c", BusMuxOut, 32'h77);
      enc = '0; #1;
      chk("bus_none", BusMuxOut, 32'd0);

      // Asynchronous clear in the middle of a cycle
      enc[PCO] = 1; marin = 1; cyc();
      #2 clear = 1'b0; #1;
      push("clr_mar", 32'd0, SRC_MAR);
      push("clr_ir", 32'd0, SRC_IR);
      push("clr_r2", 32'd0, 2);
      push("clr_hi", 32'd0, 16);
      drain();
      clear = 1'b1;
      cyc();
      rd(1, "post_clr_r1", 32'd0);
      rd(PCO, "post_clr_pc", 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got %0d want 0", 1);
      $fatal(1, "timeout");
   end
endmodule
